matmul_result_reader: RTL and testbench

- Read-side counterpart of the systolic matrix multiplier.
- On the multiplier's finish indication, snapshots the flattened result matrix and the per-PE overflow flags.
- Streams the valid N x M elements one at a time over a valid/ready interface toward the bus/register-file side.
- Frees the multiplier for the next operation while the readout is still in progress.

---
 rtl/matmul_result_reader_pkg.sv | 35 +++
 rtl/matmul_result_reader_if.sv | 36 +++
 rtl/matmul_rd_index_counter.sv | 91 +++++++++
 rtl/matmul_result_reader.sv | 144 ++++++++++++++
 tb/tb_matmul_result_reader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_result_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_result_reader_pkg
//  Description : Definitions shared by the systolic multiplier, the operand
//                loader and the result reader:
//                  - 2-bit FSM state encoding
//                  - MAX_DIM derivation from the operand and bus widths
//                  - slot index of element (row, col) in a flattened matrix
//  Revision    : 1.0 - initial release
// ============================================================================
package matmul_result_reader_pkg;

    // Width of the row/col dimension fields and index outputs.
    localparam int DIM_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } rd_state_e;

    // Largest matrix dimension the datapath supports.
    function automatic int max_dim_f(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Matrices are flattened column by column: slot = col * MAX_DIM + row.
    function automatic int slot_idx(input logic [DIM_W-1:0] row,
                                    input logic [DIM_W-1:0] col,
                                    input int               max_dim);
        return int'(col) * max_dim + int'(row);
    endfunction

endpackage : matmul_result_reader_pkg
`default_nettype wire

// File: rtl/matmul_result_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_result_reader_if
//  Description : Valid/ready element stream from the result reader toward
//                the bus / register-file side.
//                  master : result reader (drives valid, data and tags)
//                  slave  : consumer (drives ready)
//                Signals: rd_valid_o, rd_ready_i, rd_data_o[BUS_WIDTH],
//                         rd_row_o[2], rd_col_o[2], rd_ovf_o, rd_last_o
//  Revision    : 1.0 - initial release
// ============================================================================
interface matmul_result_reader_if #(
    parameter int BUS_WIDTH = 16
) ();
    import matmul_result_reader_pkg::*;

    logic                 rd_valid_o;
    logic                 rd_ready_i;
    logic [BUS_WIDTH-1:0] rd_data_o;
    logic [DIM_W-1:0]     rd_row_o;
    logic [DIM_W-1:0]     rd_col_o;
    logic                 rd_ovf_o;
    logic                 rd_last_o;

    modport master (
        output rd_valid_o, rd_data_o, rd_row_o, rd_col_o, rd_ovf_o, rd_last_o,
        input  rd_ready_i
    );

    modport slave (
        input  rd_valid_o, rd_data_o, rd_row_o, rd_col_o, rd_ovf_o, rd_last_o,
        output rd_ready_i
    );

endinterface : matmul_result_reader_if
`default_nettype wire

// File: rtl/matmul_rd_index_counter.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_rd_index_counter
//  Description : Row/col walker for the result readout. Latches and clamps
//                the dimensions on load, steps on advance, and exposes the
//                index pair (and its "last" flag) that will be current after
//                the next clock edge, so the caller can register outputs for
//                the upcoming element in the same cycle.
//  Macro       : MATMUL_RD_COL_MAJOR_EN - column-major traversal when
//                defined, row-major otherwise.
//  Ports       : clk_i, rst_ni (sync, active-low)
//                load_i      - capture dims, restart at (0,0)
//                advance_i   - step to the next element
//                n_dim_i, m_dim_i - rows-1 / cols-1 (unclamped)
//                nxt_row_o, nxt_col_o, nxt_last_o - post-edge index state
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_rd_index_counter
    import matmul_result_reader_pkg::*;
#(
    parameter int MAX_DIM = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             advance_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    output logic [DIM_W-1:0] nxt_row_o,
    output logic [DIM_W-1:0] nxt_col_o,
    output logic             nxt_last_o
);

    localparam logic [DIM_W-1:0] c_DIM_MAX = DIM_W'(MAX_DIM - 1);

    logic [DIM_W-1:0] r_row, r_col, r_n_lat, r_m_lat;
    logic [DIM_W-1:0] w_row_nxt, w_col_nxt, w_n_nxt, w_m_nxt;

    function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] d);
        return (d > c_DIM_MAX) ? c_DIM_MAX : d;
    endfunction

    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        w_n_nxt   = r_n_lat;
        w_m_nxt   = r_m_lat;
        if (load_i) begin
            w_n_nxt   = clamp_dim(n_dim_i);
            w_m_nxt   = clamp_dim(m_dim_i);
            w_row_nxt = '0;
            w_col_nxt = '0;
        end else if (advance_i) begin
`ifdef MATMUL_RD_COL_MAJOR_EN
            if (r_row < r_n_lat) begin
                w_row_nxt = r_row + 1'b1;
            end else begin
                w_row_nxt = '0;
                w_col_nxt = r_col + 1'b1;
            end
`else
            if (r_col < r_m_lat) begin
                w_col_nxt = r_col + 1'b1;
            end else begin
                w_col_nxt = '0;
                w_row_nxt = r_row + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_row   <= '0;
            r_col   <= '0;
            r_n_lat <= '0;
            r_m_lat <= '0;
        end else begin
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_n_lat <= w_n_nxt;
            r_m_lat <= w_m_nxt;
        end
    end

    assign nxt_row_o  = w_row_nxt;
    assign nxt_col_o  = w_col_nxt;
    assign nxt_last_o = (w_row_nxt == w_n_nxt) && (w_col_nxt == w_m_nxt);

endmodule : matmul_rd_index_counter
`default_nettype wire

// File: rtl/matmul_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : matmul_result_reader
//  Description : Snapshots the multiplier result matrix and overflow flags on
//                the rising edge of finish_mul_i, then streams the valid
//                (n+1) x (m+1) elements one per handshake. The multiplier is
//                free as soon as the snapshot is taken.
//  Macro       : MATMUL_RD_COL_MAJOR_EN - column-major readout order.
//  Ports       : clk_i, rst_ni (sync, active-low)
//                finish_mul_i, n_dim_i, m_dim_i, c_matrix_i, flags_i - from
//                the multiplier
//                rd_if (master) - element stream (valid/ready + tags)
//                busy_o  - snapshot held or stream in progress
//                done_o  - one-cycle pulse after the last element is taken
//  Revision    : 1.0 - initial release
// ============================================================================
module matmul_result_reader
    import matmul_result_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 16
) (
    input  logic                                           clk_i,
    input  logic                                           rst_ni,
    input  logic                                           finish_mul_i,
    input  logic [DIM_W-1:0]                               n_dim_i,
    input  logic [DIM_W-1:0]                               m_dim_i,
    input  logic [max_dim_f(BUS_WIDTH, DATA_WIDTH)**2*BUS_WIDTH-1:0] c_matrix_i,
    input  logic [max_dim_f(BUS_WIDTH, DATA_WIDTH)**2-1:0]           flags_i,
    matmul_result_reader_if.master                         rd_if,
    output logic                                           busy_o,
    output logic                                           done_o
);

    localparam int MAX_DIM  = max_dim_f(BUS_WIDTH, DATA_WIDTH);
    localparam int c_NUM_EL = MAX_DIM * MAX_DIM;
    localparam int c_SLOT_W = (c_NUM_EL > 1) ? $clog2(c_NUM_EL) : 1;

    rd_state_e                     r_state;
    logic                          r_finish_d;
    logic [c_NUM_EL*BUS_WIDTH-1:0] r_snap_mat;
    logic [c_NUM_EL-1:0]           r_snap_flags;
    logic                          r_valid, r_ovf, r_last, r_busy, r_done;
    logic [BUS_WIDTH-1:0]          r_data;
    logic [DIM_W-1:0]              r_row, r_col;

    logic                 w_trigger, w_load, w_advance, w_present;
    logic [DIM_W-1:0]     w_nxt_row, w_nxt_col;
    logic                 w_nxt_last;
    logic [c_SLOT_W-1:0]  w_slot;
    logic [BUS_WIDTH-1:0] w_elem [c_NUM_EL];

    for (genvar g = 0; g < c_NUM_EL; g++) begin : g_elem
        assign w_elem[g] = r_snap_mat[g*BUS_WIDTH +: BUS_WIDTH];
    end

    assign w_trigger = finish_mul_i && !r_finish_d;
    assign w_load    = (r_state == ST_IDLE) && w_trigger;
    // Advance only on a non-final handshake; the final one leaves the stream.
    assign w_advance = (r_state == ST_STREAM) && r_valid && rd_if.rd_ready_i && !r_last;
    // Load the output registers for the first element (one cycle after the
    // snapshot) and after every non-final handshake.
    assign w_present = ((r_state == ST_STREAM) && !r_valid) || w_advance;
    assign w_slot    = c_SLOT_W'(slot_idx(w_nxt_row, w_nxt_col, MAX_DIM));

    matmul_rd_index_counter #(
        .MAX_DIM (MAX_DIM)
    ) u_index_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (w_load),
        .advance_i  (w_advance),
        .n_dim_i    (n_dim_i),
        .m_dim_i    (m_dim_i),
        .nxt_row_o  (w_nxt_row),
        .nxt_col_o  (w_nxt_col),
        .nxt_last_o (w_nxt_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_finish_d   <= 1'b0;
            r_snap_mat   <= '0;
            r_snap_flags <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_ovf        <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_finish_d <= finish_mul_i;

            if (w_present) begin
                r_data <= w_elem[w_slot];
                r_ovf  <= r_snap_flags[w_slot];
                r_row  <= w_nxt_row;
                r_col  <= w_nxt_col;
                r_last <= w_nxt_last;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_snap_mat   <= c_matrix_i;
                        r_snap_flags <= flags_i;
                        r_busy       <= 1'b1;
                        r_state      <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                    end else if (rd_if.rd_ready_i && r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_if.rd_valid_o = r_valid;
    assign rd_if.rd_data_o  = r_data;
    assign rd_if.rd_row_o   = r_row;
    assign rd_if.rd_col_o   = r_col;
    assign rd_if.rd_ovf_o   = r_ovf;
    assign rd_if.rd_last_o  = r_last;
    assign busy_o           = r_busy;
    assign done_o           = r_done;

endmodule : matmul_result_reader
`default_nettype wire

// File: tb/tb_matmul_result_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matmul_result_reader
//  Description : Self-checking bench for matmul_result_reader. A reference
//                model expands (matrix, flags, dims) into the expected element
//                list by plain nested loops; the bench compares every
//                presented element, the latency, done/busy timing, reset
//                behaviour and non-retriggering against it.
//  Macro       : MATMUL_RD_COL_MAJOR_EN - model follows the same order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_result_reader;
    import matmul_result_reader_pkg::*;

    localparam int DW = 8;
    localparam int BW = 16;
    localparam int MD = BW / DW;
    localparam int NE = MD * MD;
    localparam logic [NE*BW-1:0] c_BASIC_MAT = 64'h012C_FFFD_0007_000A;
    localparam logic [NE-1:0]    c_BASIC_FLG = 4'b1000;

    typedef struct packed {
        logic [BW-1:0]    data;
        logic [DIM_W-1:0] row;
        logic [DIM_W-1:0] col;
        logic             ovf;
        logic             last;
    } exp_t;

    logic             clk_i        = 1'b0;
    logic             rst_ni       = 1'b0;
    logic             finish_mul_i = 1'b0;
    logic [DIM_W-1:0] n_dim_i      = '0;
    logic [DIM_W-1:0] m_dim_i      = '0;
    logic [NE*BW-1:0] c_matrix_i   = '0;
    logic [NE-1:0]    flags_i      = '0;
    logic             busy_o, done_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    matmul_result_reader_if #(.BUS_WIDTH(BW)) rd_if ();

    matmul_result_reader #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .finish_mul_i (finish_mul_i),
        .n_dim_i      (n_dim_i),
        .m_dim_i      (m_dim_i),
        .c_matrix_i   (c_matrix_i),
        .flags_i      (flags_i),
        .rd_if        (rd_if),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Expected stream: clamp dims, then walk the valid region in readout order.
    task automatic build_model(input logic [NE*BW-1:0] mat, input logic [NE-1:0] flg,
                               input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] m);
        int nc, mc;
        exp_t e;
        nc = (int'(n) > MD - 1) ? MD - 1 : int'(n);
        mc = (int'(m) > MD - 1) ? MD - 1 : int'(m);
        exp_q.delete();
`ifdef MATMUL_RD_COL_MAJOR_EN
        for (int c = 0; c <= mc; c++) begin
            for (int r = 0; r <= nc; r++) begin
`else
        for (int r = 0; r <= nc; r++) begin
            for (int c = 0; c <= mc; c++) begin
`endif
                e.data = mat[(c*MD + r)*BW +: BW];
                e.row  = DIM_W'(r);
                e.col  = DIM_W'(c);
                e.ovf  = flg[r + c*MD];
                e.last = (r == nc) && (c == mc);
                exp_q.push_back(e);
            end
        end
    endtask

    // mode: 0 = ready high, 1 = random ready, 2 = ready low 3 cycles on element 2
    // hold: cycles finish stays high after the trigger; pulse: re-raise mid-stream
    task automatic run_readout(input logic [NE*BW-1:0] mat, input logic [NE-1:0] flg,
                               input logic [DIM_W-1:0] n, input logic [DIM_W-1:0] m,
                               input int mode, input int hold, input bit pulse);
        exp_t e;
        int   accepted  = 0;
        int   stall     = 0;
        int   cyc       = 0;
        int   hold_left = hold;
        logic rdy;
        build_model(mat, flg, n, m);
        @(negedge clk_i);
        c_matrix_i       = mat;
        flags_i          = flg;
        n_dim_i          = n;
        m_dim_i          = m;
        finish_mul_i     = 1'b1;
        rd_if.rd_ready_i = 1'b0;
        @(negedge clk_i);
        check_val("valid_after_trigger", 64'(rd_if.rd_valid_o), 64'd0);
        check_val("busy_after_trigger", 64'(busy_o), 64'd1);
        c_matrix_i = {$urandom(), $urandom()};
        flags_i    = NE'($urandom());
        while (exp_q.size() > 0 && cyc < 200) begin
            @(negedge clk_i);
            cyc++;
            if (pulse)              finish_mul_i = (cyc == 2);
            else if (hold_left > 0) hold_left--;
            else                    finish_mul_i = 1'b0;
            check_val("valid", 64'(rd_if.rd_valid_o), 64'd1);
            if (rd_if.rd_valid_o) begin
                e = exp_q[0];
                check_val($sformatf("data[%0d]", accepted), 64'(rd_if.rd_data_o), 64'(e.data));
                check_val($sformatf("row[%0d]", accepted),  64'(rd_if.rd_row_o),  64'(e.row));
                check_val($sformatf("col[%0d]", accepted),  64'(rd_if.rd_col_o),  64'(e.col));
                check_val($sformatf("ovf[%0d]", accepted),  64'(rd_if.rd_ovf_o),  64'(e.ovf));
                check_val($sformatf("last[%0d]", accepted), 64'(rd_if.rd_last_o), 64'(e.last));
                check_val("done_mid", 64'(done_o), 64'd0);
                case (mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom_range(0, 1));
                    default: begin
                        if (accepted == 1 && stall < 3) begin
                            rdy = 1'b0;
                            stall++;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                endcase
                rd_if.rd_ready_i = rdy;
                if (rdy) begin
                    void'(exp_q.pop_front());
                    accepted++;
                end
            end
        end
        if (exp_q.size() > 0) begin
            check_val("stream_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk_i);
        rd_if.rd_ready_i = 1'b0;
        check_val("valid_after_last", 64'(rd_if.rd_valid_o), 64'd0);
        check_val("done_pulse", 64'(done_o), 64'd1);
        check_val("busy_in_done", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        check_val("done_clear", 64'(done_o), 64'd0);
        check_val("busy_clear", 64'(busy_o), 64'd0);
        finish_mul_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check_val("no_retrigger", 64'(rd_if.rd_valid_o), 64'd0);
        end
    endtask

    task automatic run_reset_mid();
        build_model(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd1);
        @(negedge clk_i);
        c_matrix_i       = c_BASIC_MAT;
        flags_i          = c_BASIC_FLG;
        n_dim_i          = 2'd1;
        m_dim_i          = 2'd1;
        finish_mul_i     = 1'b1;
        rd_if.rd_ready_i = 1'b1;
        @(negedge clk_i);
        finish_mul_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_elem1", 64'(rd_if.rd_data_o), 64'(exp_q[0].data));
        @(negedge clk_i);
        check_val("rst_elem2", 64'(rd_if.rd_data_o), 64'(exp_q[1].data));
        rst_ni           = 1'b0;
        rd_if.rd_ready_i = 1'b0;
        @(negedge clk_i);
        check_val("rst_valid", 64'(rd_if.rd_valid_o), 64'd0);
        check_val("rst_data",  64'(rd_if.rd_data_o),  64'd0);
        check_val("rst_row",   64'(rd_if.rd_row_o),   64'd0);
        check_val("rst_col",   64'(rd_if.rd_col_o),   64'd0);
        check_val("rst_ovf",   64'(rd_if.rd_ovf_o),   64'd0);
        check_val("rst_last",  64'(rd_if.rd_last_o),  64'd0);
        check_val("rst_busy",  64'(busy_o),           64'd0);
        check_val("rst_done",  64'(done_o),           64'd0);
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check_val("rst_no_done",  64'(done_o),           64'd0);
            check_val("rst_no_valid", 64'(rd_if.rd_valid_o), 64'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        rd_if.rd_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_val("reset_valid", 64'(rd_if.rd_valid_o), 64'd0);
        check_val("reset_data",  64'(rd_if.rd_data_o),  64'd0);
        check_val("reset_last",  64'(rd_if.rd_last_o),  64'd0);
        check_val("reset_busy",  64'(busy_o),           64'd0);
        check_val("reset_done",  64'(done_o),           64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd1, 0, 0, 1'b0);  // basic
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd1, 2, 0, 1'b0);  // backpressure
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd0, 2'd1, 0, 0, 1'b0);  // partial n=0
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd0, 0, 0, 1'b0);  // partial m=0
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd1, 0, 10, 1'b0); // level held
        run_readout(64'h1111_2222_3333_4444, 4'b0110, 2'd1, 2'd1, 0, 0, 1'b0);
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd3, 2'd2, 0, 0, 1'b1);  // clamp + pulse
        run_reset_mid();
        run_readout(c_BASIC_MAT, c_BASIC_FLG, 2'd1, 2'd1, 0, 0, 1'b0);  // restart
        for (int i = 0; i < 20; i++) begin
            run_readout({$urandom(), $urandom()}, NE'($urandom()),
                        DIM_W'($urandom_range(0, 3)), DIM_W'($urandom_range(0, 3)),
                        1, $urandom_range(0, 10), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_matmul_result_reader
`default_nettype wire
